fifo_sc_fwft_v2_0: RTL

//  Single-clock first-word-fall-through FIFO; vendor-independent successor to the v1 PMI FWFT wrapper.

---
 rtl/fifo_sc_fwft_v2_0.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_sc_fwft_v2_0.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM, one prefetch
// stage and a registered output stage, with thresholds, count, flush and sticky errors.
module fifo_sc_fwft_v2_0 #(
  parameter int DEPTH         = 1024,
  parameter int WIDTH         = 8,
  parameter int AFULL_THRESH  = 1023,
  parameter int AEMPTY_THRESH = 1,
  parameter     RAM_STYLE     = "EBR",
  parameter bit SIM_MODE      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wren,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         full,
  output logic                         afull,
  input  logic                         rden,
  output logic [WIDTH-1:0]             rdata,
  output logic                         rdata_vld,
  output logic                         aempty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  (* syn_ramstyle = RAM_STYLE *) logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_dout_q;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, ram_cnt;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rdata_vld_q, rdata_vld_d;
  logic             full_q, full_d, afull_q, afull_d, aempty_q, aempty_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             do_wr, do_pop, ovf_evt, udf_evt;
  logic             out_free, s1_take, ram_rd;

  always_comb begin
    do_wr    = wren && !full_q && !flush;
    do_pop   = rden && rdata_vld_q && !flush;
    ovf_evt  = wren && full_q && !flush;
    udf_evt  = rden && !rdata_vld_q && !flush;
    out_free = !rdata_vld_q || do_pop;
    s1_take  = out_free && s1_vld_q;
    // Words still sitting in RAM: total minus the two pipeline stages.
    ram_cnt  = count_q - CW'(s1_vld_q) - CW'(rdata_vld_q);
    ram_rd   = (!s1_vld_q || s1_take) && (ram_cnt != '0) && !flush;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      s1_vld_d    = 1'b0;
      rdata_vld_d = 1'b0;
      rdata_d     = '0;
    end else begin
      wr_ptr_d    = wr_ptr_q + AW'(do_wr);
      rd_ptr_d    = rd_ptr_q + AW'(ram_rd);
      count_d     = count_q + CW'(do_wr) - CW'(do_pop);
      s1_vld_d    = ram_rd ? 1'b1 : (s1_take ? 1'b0 : s1_vld_q);
      rdata_vld_d = out_free ? s1_vld_q : rdata_vld_q;
      rdata_d     = s1_take ? ram_dout_q : rdata_q;
    end

    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    // A fresh error event outranks a simultaneous clear.
    ovf_d    = (ovf_q && !clr_err) || ovf_evt;
    udf_d    = (udf_q && !clr_err) || udf_evt;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wdata;
    if (ram_rd) ram_dout_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      s1_vld_q    <= 1'b0;
      rdata_vld_q <= 1'b0;
      rdata_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      s1_vld_q    <= s1_vld_d;
      rdata_vld_q <= rdata_vld_d;
      rdata_q     <= rdata_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign full      = full_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign count     = count_q;
  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  generate
    if (SIM_MODE) begin : g_sim
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 1 ||
          AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
          AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_param
        $fatal(1, "fifo_sc_fwft_v2_0: illegal parameter combination");
      end
      always_ff @(posedge clk) begin
        if (rst_n && ovf_evt) $error("fifo_sc_fwft_v2_0: write while full");
        if (rst_n && udf_evt) $error("fifo_sc_fwft_v2_0: read while empty");
      end
    end
  endgenerate
endmodule
